// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO for the UART TX/RX paths with occupancy counts,
// FWFT/registered read, almost thresholds, flush and sticky errors. Parity option: UART_FIFO_PARITY_EN.
module uart_sync_fifo #(
  parameter int FIFO_AW   = 4,
  parameter int FIFO_DW   = 8,
  parameter int FIFO_FWFT = 0
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_wr_req,
  input  logic [FIFO_DW-1:0] i_data_in,
  input  logic               i_rd_req,
  input  logic               i_flush,
  input  logic               i_clr_flags,
  input  logic [FIFO_AW:0]   i_af_thr,
  input  logic [FIFO_AW:0]   i_ae_thr,
  output logic [FIFO_DW-1:0] o_data_out,
  output logic               o_valid,
  output logic [FIFO_AW:0]   o_used,
  output logic [FIFO_AW:0]   o_free,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_parity_error
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   ONE_CNT   = 1;
  localparam logic [FIFO_AW-1:0] ONE_PTR   = 1;
`ifdef UART_FIFO_PARITY_EN
  localparam int MW = FIFO_DW + 1;
`else
  localparam int MW = FIFO_DW;
`endif

  generate
    if (FIFO_AW < 1) begin : g_bad_aw
      $error("uart_sync_fifo: FIFO_AW must be >= 1");
    end
    if (FIFO_DW < 1) begin : g_bad_dw
      $error("uart_sync_fifo: FIFO_DW must be >= 1");
    end
  endgenerate

  logic [MW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   used_q;
  logic               rd_ok;
  logic               wr_ok;
  logic [MW-1:0]      wr_word;
  logic [MW-1:0]      head_word;

  assign o_used         = used_q;
  assign o_free         = DEPTH_CNT - used_q;
  assign o_empty        = (used_q == '0);
  assign o_full         = (used_q == DEPTH_CNT);
  assign o_almost_full  = (used_q >= i_af_thr);
  assign o_almost_empty = (used_q <= i_ae_thr);

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign rd_ok = i_rd_req && !o_empty && !i_flush;
  assign wr_ok = i_wr_req && !i_flush && (!o_full || rd_ok);

`ifdef UART_FIFO_PARITY_EN
  assign wr_word = {^i_data_in, i_data_in};
`else
  assign wr_word = i_data_in;
`endif
  assign head_word = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_q <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE_PTR;
      if (rd_ok) rd_ptr <= rd_ptr + ONE_PTR;
      if (wr_ok && !rd_ok)      used_q <= used_q + ONE_CNT;
      else if (rd_ok && !wr_ok) used_q <= used_q - ONE_CNT;
    end
  end

  // Sticky errors: a new error in the clearing cycle wins.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_req && !wr_ok && !i_flush) o_overflow <= 1'b1;
      else if (i_clr_flags)               o_overflow <= 1'b0;
      if (i_rd_req && o_empty && !i_flush) o_underflow <= 1'b1;
      else if (i_clr_flags)                o_underflow <= 1'b0;
    end
  end

  generate
    if (FIFO_FWFT != 0) begin : g_fwft
      assign o_valid    = !o_empty;
      assign o_data_out = o_valid ? head_word[FIFO_DW-1:0] : '0;
`ifdef UART_FIFO_PARITY_EN
      assign o_parity_error = o_valid && (^head_word);
`else
      assign o_parity_error = 1'b0;
`endif
    end else begin : g_reg
      logic [FIFO_DW-1:0] dout_q;
      logic               valid_q;

      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= head_word[FIFO_DW-1:0];
        end
      end

      assign o_data_out = dout_q;
      assign o_valid    = valid_q;
`ifdef UART_FIFO_PARITY_EN
      logic par_q;
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)    par_q <= 1'b0;
        else if (rd_ok) par_q <= ^head_word;
      end
      assign o_parity_error = valid_q && par_q;
`else
      assign o_parity_error = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: registered-read and FWFT instances driven in lockstep against a queue scoreboard.
module tb_uart_sync_fifo;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          i_clk = 1'b0;
  logic          i_nrst;
  logic          wr, rd, flush, clr;
  logic [DW-1:0] din;
  logic [AW:0]   af_thr, ae_thr;

  logic [DW-1:0] r_data, f_data;
  logic          r_valid, f_valid;
  logic [AW:0]   r_used, r_free, f_used, f_free;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_perr;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_perr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] qd[$];
  bit            qb[$];
  int            m_used;
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_last;

  always #5 i_clk = ~i_clk;

  uart_sync_fifo #(.FIFO_AW(AW), .FIFO_DW(DW), .FIFO_FWFT(0)) dut_r (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_wr_req(wr), .i_data_in(din), .i_rd_req(rd),
    .i_flush(flush), .i_clr_flags(clr), .i_af_thr(af_thr), .i_ae_thr(ae_thr),
    .o_data_out(r_data), .o_valid(r_valid), .o_used(r_used), .o_free(r_free),
    .o_full(r_full), .o_empty(r_empty), .o_almost_full(r_af), .o_almost_empty(r_ae),
    .o_overflow(r_ovf), .o_underflow(r_udf), .o_parity_error(r_perr));

  uart_sync_fifo #(.FIFO_AW(AW), .FIFO_DW(DW), .FIFO_FWFT(1)) dut_f (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_wr_req(wr), .i_data_in(din), .i_rd_req(rd),
    .i_flush(flush), .i_clr_flags(clr), .i_af_thr(af_thr), .i_ae_thr(ae_thr),
    .o_data_out(f_data), .o_valid(f_valid), .o_used(f_used), .o_free(f_free),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_overflow(f_ovf), .o_underflow(f_udf), .o_parity_error(f_perr));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input bit rd_ok, input bit pop_bad);
    chk("r_used",   32'(r_used),  32'(m_used));
    chk("r_free",   32'(r_free),  32'(D - m_used));
    chk("r_full",   32'(r_full),  32'(m_used == D));
    chk("r_empty",  32'(r_empty), 32'(m_used == 0));
    chk("r_af",     32'(r_af),    32'(m_used >= int'(af_thr)));
    chk("r_ae",     32'(r_ae),    32'(m_used <= int'(ae_thr)));
    chk("r_ovf",    32'(r_ovf),   32'(m_ovf));
    chk("r_udf",    32'(r_udf),   32'(m_udf));
    chk("r_valid",  32'(r_valid), 32'(rd_ok));
    chk("r_data",   32'(r_data),  32'(m_last));
    chk("r_perr",   32'(r_perr),  32'(rd_ok && pop_bad));
    chk("f_used",   32'(f_used),  32'(m_used));
    chk("f_free",   32'(f_free),  32'(D - m_used));
    chk("f_full",   32'(f_full),  32'(m_used == D));
    chk("f_empty",  32'(f_empty), 32'(m_used == 0));
    chk("f_af",     32'(f_af),    32'(m_used >= int'(af_thr)));
    chk("f_ae",     32'(f_ae),    32'(m_used <= int'(ae_thr)));
    chk("f_ovf",    32'(f_ovf),   32'(m_ovf));
    chk("f_udf",    32'(f_udf),   32'(m_udf));
    chk("f_valid",  32'(f_valid), 32'(m_used != 0));
    if (m_used != 0) begin
      chk("f_data", 32'(f_data),  32'(qd[0]));
      chk("f_perr", 32'(f_perr),  32'(qb[0]));
    end else begin
      chk("f_perr", 32'(f_perr),  32'd0);
    end
  endtask

  task automatic model_reset();
    qd.delete();
    qb.delete();
    m_used = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_last = '0;
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit fl, input bit cl);
    bit rd_ok, wr_ok, ovf_set, udf_set, pop_bad;
    wr = w; din = d; rd = r; flush = fl; clr = cl;
    rd_ok   = r && (m_used != 0) && !fl;
    wr_ok   = w && !fl && ((m_used != D) || rd_ok);
    ovf_set = w && !wr_ok && !fl;
    udf_set = r && (m_used == 0) && !fl;
    pop_bad = 1'b0;
    if (rd_ok) begin
      m_last  = qd.pop_front();
      pop_bad = qb.pop_front();
    end
    if (wr_ok) begin
      qd.push_back(d);
      qb.push_back(1'b0);
    end
    if (fl) begin
      qd.delete();
      qb.delete();
    end
    m_used = qd.size();
    m_ovf  = ovf_set ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_udf  = udf_set ? 1'b1 : (cl ? 1'b0 : m_udf);
    @(posedge i_clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
    check_all(rd_ok, pop_bad);
  endtask

  initial begin
    i_nrst = 1'b0;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0; din = '0;
    af_thr = 3'd3; ae_thr = 3'd1;
    model_reset();
    #12;
    check_all(1'b0, 1'b0);
    i_nrst = 1'b1;

    // Fill to full, then overflow and clear
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    // Full with concurrent pop and push
    step(1, 8'h55, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    // Underflow, then write+read on empty
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'hA5, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    // FWFT fall-through of a single word
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    // Threshold walk 0..4 with af=3, ae=1
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    // Flush with 3 words dominates concurrent write/read
    step(1, 8'h77, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);

`ifdef UART_FIFO_PARITY_EN
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0);
    dut_r.mem[0] = dut_r.mem[0] ^ 9'h001;
    dut_f.mem[0] = dut_f.mem[0] ^ 9'h001;
    qd[0] = qd[0] ^ 8'h01;
    qb[0] = 1'b1;
    #1;
    check_all(1'b0, 1'b0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
`endif

    // Random traffic with varying thresholds (including values above depth)
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) begin
        af_thr = 3'($urandom_range(0, 7));
        ae_thr = 3'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between edges
    af_thr = 3'd3; ae_thr = 3'd1;
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h5A, 0, 0, 0);
    step(1, 8'h6B, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    #2;
    i_nrst = 1'b0;
    model_reset();
    #1;
    check_all(1'b0, 1'b0);
    #1;
    i_nrst = 1'b1;
    step(0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
